fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the instruction/address width.
REQ-002 Parameter DEPTH, default 4, SHALL set queue entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 32'h01000000, SHALL set the first fetch address after reset.
REQ-004 Port clock, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset (0 = in reset).
REQ-006 Port req_valid, output, 1 bit, SHALL indicate a fetch request to instruction memory.
REQ-007 Port req_ready, input, 1 bit, SHALL indicate memory accepts the request this cycle.
REQ-008 Port req_addr, output, XLEN bits, SHALL carry the word-aligned fetch address.
REQ-009 Port resp_valid, input, 1 bit, SHALL mark returned instruction data, in request order, with no backpressure.
REQ-010 Port resp_data, input, XLEN bits, SHALL carry the returned instruction word.
REQ-011 Port set_PC, input, 1 bit, SHALL request a redirect (branch/jump taken).
REQ-012 Port new_PC, input, XLEN bits, SHALL carry the redirect target; bits [1:0] SHALL be treated as zero.
REQ-013 Port instr_valid, output, 1 bit, SHALL indicate the head entry is valid.
REQ-014 Port instr_ready, input, 1 bit, SHALL indicate decode consumes the head this cycle.
REQ-015 Port instr, output, XLEN bits, SHALL carry the head instruction word.
REQ-016 Port instr_pc, output, XLEN bits, SHALL carry the address of the head instruction.

Function
REQ-017 Internal state SHALL be: fetch_pc, resp_pc, queue (DEPTH x {pc, instr}), occupancy count, outstanding count, and discard count.
REQ-018 req_valid SHALL be 1 iff set_PC=0 and occupancy+outstanding < DEPTH; req_addr SHALL equal fetch_pc.
REQ-019 On req_valid&&req_ready, fetch_pc SHALL advance by 4 (modulo 2^XLEN, wrapping) and outstanding SHALL increment.
REQ-020 On resp_valid, outstanding SHALL decrement; if discard>0, the response SHALL be dropped and discard decremented; otherwise {resp_pc, resp_data} SHALL be pushed and resp_pc advanced by 4.
REQ-021 Invariant occupancy+outstanding <= DEPTH SHALL hold, so a non-discarded response always finds space.
REQ-022 instr_valid SHALL equal (occupancy != 0); instr/instr_pc SHALL present the head entry combinationally from storage.
REQ-023 On instr_valid&&instr_ready, the head SHALL pop; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 Latency: a response accepted in cycle t SHALL be visible at instr_valid in cycle t+1 if the queue was empty.
REQ-025 On set_PC=1: queue SHALL be flushed (occupancy=0) at the next edge; fetch_pc and resp_pc SHALL load new_PC; discard SHALL load outstanding minus resp_valid (net of any concurrent discard decrement); no request SHALL issue that cycle.
REQ-026 A response arriving in the set_PC cycle SHALL be dropped and SHALL NOT appear at the output.
REQ-027 A pop in the set_PC cycle SHALL complete; the flush takes precedence over any concurrent push.
REQ-028 Back-to-back set_PC cycles SHALL each apply REQ-025; the last target wins.
REQ-029 Pointers SHALL wrap modulo DEPTH; counters SHALL be clog2(DEPTH)+1 bits wide.

Reset
REQ-030 While reset=0: fetch_pc=resp_pc=RESET_PC, occupancy=outstanding=discard=0, req_valid=0, instr_valid=0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; responses after release SHALL be accepted as new.
REQ-032 The first request SHALL issue in the first cycle after reset deasserts with req_ready=1.

Verification
REQ-033 Reset release, req_ready=1, 1-cycle memory -> req_addr 0x01000000, 0x01000004, ...; instr_pc follows same sequence.
REQ-034 DEPTH=4, instr_ready=0 -> exactly 4 requests issue, then req_valid=0; one pop re-enables exactly one request.
REQ-035 2 outstanding, set_PC=1 new_PC=0x01000100 -> next 2 responses dropped; first instr_pc=0x01000100.
REQ-036 set_PC coincident with resp_valid and pop -> response dropped, pop completes, discard=outstanding-1.
REQ-037 new_PC=0x01000103 -> req_addr=0x01000100; fetch_pc 0xFFFFFFFC wraps to 0x00000000.
REQ-038 Reset low with queue full and 3 outstanding -> all outputs per REQ-030 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between a fetch unit and decode.
// Issues word-aligned fetch requests, matches in-order memory responses to
// their addresses, and buffers them for decode. A redirect flushes the queue
// and marks every still-in-flight response for silent discard.
module fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
   input  logic            clock,
   input  logic            reset,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_data,
   input  logic            set_PC,
   input  logic [XLEN-1:0] new_PC,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);
   localparam logic [XLEN-1:0] PC_ZERO  = {XLEN{1'b0}};

   // Force a redirect target onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // Architectural state
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] resp_pc_r;
   logic [XLEN-1:0] pc_mem_r    [DEPTH];
   logic [XLEN-1:0] instr_mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   occ_r;
   logic [CW-1:0]   out_r;
   logic [CW-1:0]   disc_r;

   // Handshake and next-state terms
   logic [CW:0]     inflight_s;
   logic            room_s;
   logic            req_fire_s;
   logic            pop_s;
   logic            push_s;
   logic            resp_dec_s;
   logic            disc_drop_s;
   logic [CW-1:0]   occ_next_s;
   logic [CW-1:0]   out_next_s;
   logic [CW-1:0]   disc_next_s;

   // Handshakes: request gating by reserved space, pop, push and drop qualification.
   always_comb begin
      inflight_s  = {1'b0, occ_r} + {1'b0, out_r};
      room_s      = (inflight_s < {1'b0, DEPTH_C});
      // reset is folded in so the request line is low while the block is held in reset
      req_valid   = reset & ~set_PC & room_s;
      req_addr    = fetch_pc_r;
      req_fire_s  = req_valid & req_ready;
      instr_valid = (occ_r != CNT_ZERO);
      instr       = instr_mem_r[rd_ptr_r];
      instr_pc    = pc_mem_r[rd_ptr_r];
      pop_s       = instr_valid & instr_ready;
      // a response with nothing outstanding (stale after reset) must not underflow the count
      resp_dec_s  = resp_valid & (out_r != CNT_ZERO);
      disc_drop_s = resp_valid & (disc_r != CNT_ZERO);
      // space check keeps storage safe even if a stray response breaks the reservation
      push_s      = resp_valid & ~set_PC & (disc_r == CNT_ZERO) &
                    ((occ_r != DEPTH_C) | pop_s);
   end

   // Next values of the occupancy, outstanding and discard counters.
   always_comb begin
      occ_next_s  = occ_r;
      out_next_s  = out_r + CW'(req_fire_s) - CW'(resp_dec_s);
      disc_next_s = disc_r;
      if (set_PC) begin
         occ_next_s  = CNT_ZERO;
         // every response still in flight after this cycle belongs to the old path
         disc_next_s = out_r - CW'(resp_dec_s);
      end else begin
         occ_next_s = occ_r + CW'(push_s) - CW'(pop_s);
         if (disc_drop_s) begin
            disc_next_s = disc_r - CNT_ONE;
         end else begin
            disc_next_s = disc_r;
         end
      end
   end

   // Program counters, queue pointers and counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_r <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         occ_r      <= CNT_ZERO;
         out_r      <= CNT_ZERO;
         disc_r     <= CNT_ZERO;
      end else begin
         occ_r  <= occ_next_s;
         out_r  <= out_next_s;
         disc_r <= disc_next_s;
         if (set_PC) begin
            fetch_pc_r <= align_word(new_PC);
            resp_pc_r  <= align_word(new_PC);
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
         end else begin
            if (req_fire_s) begin
               fetch_pc_r <= fetch_pc_r + PC_STEP;
            end else begin
               fetch_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
               resp_pc_r <= resp_pc_r + PC_STEP;
               wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end else begin
               resp_pc_r <= resp_pc_r;
               wr_ptr_r  <= wr_ptr_r;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
               rd_ptr_r <= rd_ptr_r;
            end
         end
      end
   end

   // Queue storage: each accepted response is written with the address it was fetched from.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_r[i]    <= PC_ZERO;
            instr_mem_r[i] <= PC_ZERO;
         end
      end else if (push_s) begin
         pc_mem_r[wr_ptr_r]    <= resp_pc_r;
         instr_mem_r[wr_ptr_r] <= resp_data;
      end else begin
         pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
         instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scenario tasks with a memory model and
// a scoreboard of expected {pc, instr} entries checked as decode sees them.
module tb_fetch_queue;

   localparam logic [31:0] RST_PC = 32'h0100_0000;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        set_pc;
   logic [31:0] new_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q [$];   // expected {pc, instr}
   logic [31:0] mem_q [$];   // accepted request addresses awaiting a response
   logic        mem_en;
   int          m_out;
   int          m_disc;
   logic [31:0] m_resp_pc;
   int          fire_cnt;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .set_PC(set_pc), .new_PC(new_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Clear bench bookkeeping to the post-reset state.
   task automatic clear_model();
      exp_q.delete();
      mem_q.delete();
      m_out     = 0;
      m_disc    = 0;
      m_resp_pc = RST_PC;
      fire_cnt  = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0; req_ready = 1'b0; instr_ready = 1'b0; set_pc = 1'b0;
      new_pc = 32'h0; resp_valid = 1'b0; resp_data = 32'h0; mem_en = 1'b0;
      clear_model();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // One clock cycle: scoreboard check of the head, bookkeeping, then memory drive.
   task automatic tick();
      #1;
      total++;
      if (instr_valid !== (exp_q.size() != 0)) begin
         bad++;
         $display("FAIL sb_valid: got %b want %b", instr_valid, (exp_q.size() != 0));
      end
      if (instr_valid === 1'b1 && exp_q.size() != 0) begin
         total++;
         if ({instr_pc, instr} !== exp_q[0]) begin
            bad++;
            $display("FAIL sb_entry: got pc=%h instr=%h want pc=%h instr=%h",
                     instr_pc, instr, exp_q[0][63:32], exp_q[0][31:0]);
         end
      end
      if (instr_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (resp_valid) begin
         if (m_out > 0) m_out--;
         if (!set_pc) begin
            if (m_disc > 0) m_disc--;
            else begin
               exp_q.push_back({m_resp_pc, resp_data});
               m_resp_pc = m_resp_pc + 32'd4;
            end
         end
      end
      if (set_pc) begin
         exp_q.delete();
         m_resp_pc = {new_pc[31:2], 2'b00};
         m_disc    = m_out;
      end
      if (req_valid && req_ready) begin
         mem_q.push_back(req_addr);
         m_out++;
         fire_cnt++;
      end
      @(posedge clock);
      @(negedge clock);
      if (mem_en && mem_q.size() != 0) begin
         resp_valid = 1'b1;
         resp_data  = mem_data(mem_q.pop_front());
      end else begin
         resp_valid = 1'b0;
         resp_data  = 32'h0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_ready = 1'b0; instr_ready = 1'b0; set_pc = 1'b0;
      new_pc = 32'h0; resp_valid = 1'b0; resp_data = 32'h0; mem_en = 1'b0;
      clear_model();
      #2 reset = 1'b0;
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
      total++; if (req_addr !== RST_PC) begin bad++; $display("FAIL rst_req_addr: got %h want %h", req_addr, RST_PC); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      req_ready = 1'b1;
      #1;
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", req_valid); end
      total++; if (req_addr !== RST_PC) begin bad++; $display("FAIL first_addr: got %h want %h", req_addr, RST_PC); end
      tick();
   endtask

   task automatic test_sequence();
      logic [31:0] exp_addr;
      logic [31:0] exp_ipc;
      int          n_instr;
      do_reset();
      req_ready = 1'b1; instr_ready = 1'b1; mem_en = 1'b1;
      exp_addr = RST_PC; exp_ipc = RST_PC; n_instr = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL seq_req_valid c%0d: got %b want 1", c, req_valid); end
         total++; if (req_addr !== exp_addr) begin bad++; $display("FAIL seq_addr c%0d: got %h want %h", c, req_addr, exp_addr); end
         exp_addr = exp_addr + 32'd4;
         if (instr_valid === 1'b1) begin
            total++; if (instr_pc !== exp_ipc) begin bad++; $display("FAIL seq_ipc: got %h want %h", instr_pc, exp_ipc); end
            exp_ipc = exp_ipc + 32'd4;
            n_instr++;
         end
         tick();
      end
      total++; if (n_instr != 10) begin bad++; $display("FAIL seq_latency: got %0d instrs want 10", n_instr); end
   endtask

   task automatic test_full();
      do_reset();
      req_ready = 1'b1; instr_ready = 1'b0; mem_en = 1'b1;
      for (int c = 0; c < 10; c++) tick();
      total++; if (fire_cnt != 4) begin bad++; $display("FAIL full_reqs: got %0d want 4", fire_cnt); end
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_stall: got %b want 0", req_valid); end
      instr_ready = 1'b1;
      fire_cnt = 0;
      tick();
      instr_ready = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      total++; if (fire_cnt != 1) begin bad++; $display("FAIL full_refill: got %0d want 1", fire_cnt); end
   endtask

   task automatic test_redirect();
      bit found;
      do_reset();
      req_ready = 1'b1; instr_ready = 1'b1; mem_en = 1'b0;
      tick();
      tick();
      set_pc = 1'b1; new_pc = 32'h0100_0100; mem_en = 1'b1;
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_noreq: got %b want 0", req_valid); end
      tick();
      set_pc = 1'b0;
      #1;
      total++; if (req_addr !== 32'h0100_0100) begin bad++; $display("FAIL redir_addr: got %h want 01000100", req_addr); end
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         #1;
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            total++; if (instr_pc !== 32'h0100_0100) begin bad++; $display("FAIL redir_ipc: got %h want 01000100", instr_pc); end
         end
         tick();
      end
      total++; if (!found) begin bad++; $display("FAIL redir_timeout: got no instr want one within 20 cycles"); end
   endtask

   task automatic test_coincident();
      bit found;
      do_reset();
      req_ready = 1'b1; instr_ready = 1'b0; mem_en = 1'b0;
      tick(); tick(); tick();
      req_ready = 1'b0; mem_en = 1'b1;
      tick();
      tick();
      set_pc = 1'b1; new_pc = 32'h0100_0200; instr_ready = 1'b1;
      #1;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL coin_head: got %b want 1", instr_valid); end
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL coin_resp: got %b want 1", resp_valid); end
      tick();
      set_pc = 1'b0; req_ready = 1'b1;
      #1;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL coin_flush: got %b want 0", instr_valid); end
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         #1;
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            total++; if (instr_pc !== 32'h0100_0200) begin bad++; $display("FAIL coin_ipc: got %h want 01000200", instr_pc); end
         end
         tick();
      end
      total++; if (!found) begin bad++; $display("FAIL coin_timeout: got no instr want one within 20 cycles"); end
   endtask

   task automatic test_align_wrap();
      bit found;
      do_reset();
      req_ready = 1'b0; instr_ready = 1'b1; mem_en = 1'b1;
      set_pc = 1'b1; new_pc = 32'h0100_0103;
      tick();
      set_pc = 1'b0;
      #1;
      total++; if (req_addr !== 32'h0100_0100) begin bad++; $display("FAIL align_addr: got %h want 01000100", req_addr); end
      tick();
      set_pc = 1'b1; new_pc = 32'h0000_0040;
      tick();
      new_pc = 32'hFFFF_FFFE;
      tick();
      set_pc = 1'b0; req_ready = 1'b1;
      #1;
      total++; if (req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL b2b_addr: got %h want fffffffc", req_addr); end
      tick();
      #1;
      total++; if (req_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", req_addr); end
      tick();
      req_ready = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         #1;
         if (instr_valid === 1'b1) begin
            found = 1'b1;
            total++; if (instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_ipc: got %h want fffffffc", instr_pc); end
         end
         tick();
      end
      total++; if (!found) begin bad++; $display("FAIL wrap_timeout: got no instr want one within 10 cycles"); end
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      req_ready = 1'b1; instr_ready = 1'b0; mem_en = 1'b0;
      tick(); tick(); tick();
      req_ready = 1'b0; mem_en = 1'b1;
      tick(); tick();
      #3 reset = 1'b0;
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL arst_req_valid: got %b want 0", req_valid); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL arst_instr_valid: got %b want 0", instr_valid); end
      total++; if (req_addr !== RST_PC) begin bad++; $display("FAIL arst_req_addr: got %h want %h", req_addr, RST_PC); end
      clear_model();
      mem_en = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      resp_valid = 1'b1; resp_data = 32'hCAFE_F00D;
      tick();
      #1;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stale_valid: got %b want 1", instr_valid); end
      total++; if (instr_pc !== RST_PC) begin bad++; $display("FAIL stale_ipc: got %h want %h", instr_pc, RST_PC); end
      total++; if (instr !== 32'hCAFE_F00D) begin bad++; $display("FAIL stale_instr: got %h want cafef00d", instr); end
      tick();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_full();
      test_redirect();
      test_coincident();
      test_align_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
